// File: rtl/uart_tx_engine.sv
// UART transmitter: accepts a word on send/busy handshake and shifts out start, data (LSB first)
// and stop bits on tx_o, with bit timing from an internal cycle counter.
module uart_tx_engine #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 send,
  output logic                 busy,
  output logic                 done,
  output logic                 tx_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               r_state;
  logic [CntW-1:0]      r_cnt;
  logic [IdxW-1:0]      r_bit_idx;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_tx;

  logic w_bit_end;
  logic w_last_data;
  logic w_last_stop;
  logic w_pre_done;

  assign w_bit_end   = (r_cnt == CntW'(CLKS_PER_BIT - 1));
  assign w_last_data = (r_bit_idx == IdxW'(DATA_BITS - 1));
  assign w_last_stop = (STOP_BITS == 1) || r_stop_cnt;
  // done is registered, so it is armed one cycle before the final stop cycle
  assign w_pre_done  = (r_state == StStop) && w_last_stop &&
                       (r_cnt == CntW'(CLKS_PER_BIT - 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_done <= w_pre_done;
      r_cnt  <= (r_state == StIdle || w_bit_end) ? '0 : r_cnt + CntW'(1);
      case (r_state)
        StIdle: begin
          r_tx <= 1'b1;
          if (send) begin
            r_shift <= data;
            r_busy  <= 1'b1;
            r_tx    <= 1'b0;
            r_state <= StStart;
          end
        end
        StStart: begin
          if (w_bit_end) begin
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= StData;
          end
        end
        StData: begin
          if (w_bit_end) begin
            if (w_last_data) begin
              r_stop_cnt <= 1'b0;
              r_tx       <= 1'b1;
              r_state    <= StStop;
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + IdxW'(1);
            end
          end
        end
        StStop: begin
          if (w_bit_end) begin
            if (w_last_stop) begin
              r_stop_cnt <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= StIdle;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign tx_o = r_tx;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: two parameterisations, each cycle checked against a frame model
// that derives tx/busy/done from the cycle offset after the accepting edge.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       send1;
  logic [7:0] data1;
  logic       busy1, done1, tx1;
  logic       send2;
  logic [6:0] data2;
  logic       busy2, done2, tx2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) u_dut8 (
    .clk(clk), .reset(reset), .data(data1), .send(send1),
    .busy(busy1), .done(done1), .tx_o(tx1)
  );

  uart_tx_engine #(.CLKS_PER_BIT(3), .DATA_BITS(7), .STOP_BITS(2)) u_dut7 (
    .clk(clk), .reset(reset), .data(data2), .send(send2),
    .busy(busy2), .done(done2), .tx_o(tx2)
  );

  // {tx, busy, done} at offset t cycles after the accepting edge (t<1 or t>F means idle)
  function automatic logic [2:0] model(int t, logic [7:0] d, int cpb, int db, int sb);
    int f;
    int b;
    logic bit_v;
    f = (1 + db + sb) * cpb;
    if (t < 1 || t > f) return 3'b100;
    b = (t - 1) / cpb;
    if (b == 0) bit_v = 1'b0;
    else if (b <= db) bit_v = d[b-1];
    else bit_v = 1'b1;
    return {bit_v, 1'b1, (t == f)};
  endfunction

  function automatic logic [2:0] obs(bit sel);
    return sel ? {tx2, busy2, done2} : {tx1, busy1, done1};
  endfunction

  task automatic check(string tag, logic [2:0] got, logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: tx/busy/done got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(bit sel, logic s, logic [7:0] d);
    if (sel) begin
      send2 = s;
      data2 = d[6:0];
    end else begin
      send1 = s;
      data1 = d;
    end
  endtask

  // mode 0: single frame; 1: extra sends and data change while busy; 2: send held, two frames
  task automatic run(bit sel, int mode, logic [7:0] d1, logic [7:0] d2, int tail);
    int cpb, db, sb, f, total;
    logic       s;
    logic [7:0] dv;
    logic [2:0] exp;
    cpb = sel ? 3 : 4;
    db  = sel ? 7 : 8;
    sb  = sel ? 2 : 1;
    f   = (1 + db + sb) * cpb;
    total = (mode == 2) ? 2 * f + 1 + tail : f + tail;
    dv = d1;
    @(negedge clk);
    drive(sel, 1'b1, dv);
    for (int t = 1; t <= total; t++) begin
      @(negedge clk);
      if (mode == 2 && t > f + 1) exp = model(t - f - 1, d2, cpb, db, sb);
      else exp = model(t, d1, cpb, db, sb);
      check($sformatf("m%0d_d%0d_%02h_t%0d", mode, sel, d1, t), obs(sel), exp);
      s = 1'b0;
      if (mode == 1) begin
        s = (t == 5 || t == 20);
        if (t == 2) dv = 8'h00;
        if (t == 5) dv = 8'h3C;
      end else if (mode == 2) begin
        s = (t <= f + 1);
        if (t == 3) dv = d2;
      end
      drive(sel, s, dv);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [2:0] exp;

    // Reset with send asserted must not start anything
    reset = 1'b1;
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, 8'h00);
    repeat (3) begin
      @(negedge clk);
      check("reset_d8", obs(1'b0), 3'b100);
      check("reset_d7", obs(1'b1), 3'b100);
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_%0d", i), obs(1'b0), 3'b100);
    end

    run(1'b0, 0, 8'hA5, 8'h00, 6);
    run(1'b0, 1, 8'hA5, 8'h00, 40);
    run(1'b0, 2, 8'h55, 8'hAA, 6);

    // Reset mid-frame during the data bits
    d = 8'($urandom);
    @(negedge clk);
    drive(1'b0, 1'b1, d);
    for (int t = 1; t <= 15; t++) begin
      @(negedge clk);
      exp = model(t, d, 4, 8, 1);
      check($sformatf("pre_abort_t%0d", t), obs(1'b0), exp);
      drive(1'b0, 1'b0, d);
    end
    reset = 1'b1;
    #1;
    check("abort_async", obs(1'b0), 3'b100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_hold_%0d", i), obs(1'b0), 3'b100);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("abort_idle_%0d", i), obs(1'b0), 3'b100);
    end
    run(1'b0, 0, 8'h0F, 8'h00, 3);

    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(1'b0, 0, d, 8'h00, 2);
    end
    run(1'b0, 2, 8'($urandom), 8'($urandom), 3);

    run(1'b1, 0, 8'h41, 8'h00, 4);
    for (int i = 0; i < 2; i++) begin
      d = {1'b0, 7'($urandom)};
      run(1'b1, 0, d, 8'h00, 2);
    end
    run(1'b1, 2, {1'b0, 7'($urandom)}, {1'b0, 7'($urandom)}, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Serial transmitter for the on-board UART link, the transmit counterpart of the existing receive path. It accepts a parallel byte through a send/busy handshake and shifts out an 8N1-style asynchronous frame on `tx_o`: start bit, data bits LSB first, then stop bit(s). Bit timing comes from an internal cycle counter, so no external divided clock is required. The block sits between the command/response logic and the board TX pin.

## Interface

- `CLKS_PER_BIT`, default 868: `clk` cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame, range 5–8.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.

- `clk`  in  1  system clock; reset reset, asynchronous, active-high; clock clk.
- `reset`  in  1  asynchronous, active-high reset.
- `data`  in  DATA_BITS  byte to transmit; sampled only when a send is accepted.
- `send`  in  1  request to transmit; level-sampled on the `clk` rising edge.
- `busy`  out  1  high while a frame is in progress; registered.
- `done`  out  1  one-cycle pulse in the final cycle of the last stop bit; registered.
- `tx_o`  out  1  serial line; idle high; registered, glitch-free.

## Operation

- States: IDLE, START, DATA, STOP.
- Reset (asynchronous) values: state=IDLE, `tx_o`=1, `busy`=0, `done`=0, all counters 0, shift register 0.
- IDLE: `tx_o`=1. If `send`=1 at a clock edge, latch `data` into the shift register, clear the cycle counter, and go to START.
- START: `tx_o`=0 for CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
- DATA: `tx_o`=shift[0] for CLKS_PER_BIT cycles. At the end of each bit, shift right and increment the bit index. After bit DATA_BITS−1, go to STOP.
- STOP: `tx_o`=1 for STOP_BITS×CLKS_PER_BIT cycles. `done`=1 in the last of those cycles. Then go to IDLE.
- Cycle counter: width clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT−1 and wraps to 0 at each bit boundary; it never exceeds CLKS_PER_BIT−1. A separate stop-bit count handles STOP_BITS=2.
- `send` while `busy`=1 is ignored: it is not queued and does not alter the frame.
- `data` changes after acceptance have no effect on the frame in flight.
- `reset` mid-frame aborts immediately: `tx_o` returns to 1 asynchronously, no `done` pulse is issued, and the next frame starts only on a fresh `send`.

## Timing

- Send accepted at edge N means `busy`=1 and `tx_o`=0 (start bit) from cycle N+1.
- Frame length F = (1 + DATA_BITS + STOP_BITS) × CLKS_PER_BIT cycles, occupying cycles N+1 … N+F.
- Data bit k occupies cycles N+1+(1+k)×CLKS_PER_BIT … N+(2+k)×CLKS_PER_BIT.
- `done`=1 only in cycle N+F. `busy`=0 from cycle N+F+1.
- Earliest next accept is at edge N+F+1, with its start bit at N+F+2. This gives a minimum of one full-high idle cycle between back-to-back frames.
- `busy` and `tx_o` never glitch within a bit period: both are driven from flops only.

## Test plan

- Reset: assert `reset` with `send`=1 and `data`=0xFF. Required: `tx_o`=1, `busy`=0, `done`=0 throughout reset and for 10 cycles after release with `send`=0.
- Single frame (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1): one-cycle `send` with `data`=0xA5 at edge N. Required on `tx_o`, 4 cycles per bit: 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop). `busy` high for cycles N+1…N+40; `done` only at N+40.
- Send during busy: second `send` with `data`=0x3C at cycles N+5 and N+20, and `data` changed to 0x00 at N+2. Required: the frame still carries 0xA5 and no second frame follows.
- Back-to-back: hold `send`=1 continuously with `data`=0x55 then 0xAA. Required: two frames, second start bit at N+42, `tx_o`=1 in cycle N+41, two `done` pulses at N+40 and N+81.
- Reset mid-frame: assert `reset` at N+15 during the data bits. Required: `tx_o`=1 and `busy`=0 in the same cycle (asynchronous), no `done`. A subsequent `send` of 0x0F produces a correct full frame.
- Parameter variant (CLKS_PER_BIT=3, DATA_BITS=7, STOP_BITS=2): send 0x41. Required: frame 0,1,0,0,0,0,0,1,1,1 at 3 cycles per bit, F=30, `done` at N+30.
